// File: rtl/ex_mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The pipeline side uses the master modport and the unit uses the slave modport.
interface ex_mdu_if #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
);
    logic                 i_valid;
    logic [2:0]           i_op;
    logic [XLEN-1:0]      i_rs1_data;
    logic [XLEN-1:0]      i_rs2_data;
    logic [REGADDR_W-1:0] i_rd_addr;
    logic                 i_flush;
    logic                 o_ready;
    logic                 o_hold;
    logic                 o_valid;
    logic                 o_rd_we;
    logic [REGADDR_W-1:0] o_rd_addr;
    logic [XLEN-1:0]      o_rd_data;

    modport master (
        output i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
        input  o_ready, o_hold, o_valid, o_rd_we, o_rd_addr, o_rd_data
    );

    modport slave (
        input  i_valid, i_op, i_rs1_data, i_rs2_data, i_rd_addr, i_flush,
        output o_ready, o_hold, o_valid, o_rd_we, o_rd_addr, o_rd_data
    );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: one result bit per cycle,
// with a fast path for divide-by-zero and signed-overflow division.
module ex_mdu #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input logic     i_clk,
    input logic     i_reset,
    ex_mdu_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [2:0]           op;
    logic                 neg;
    logic [REGADDR_W-1:0] rd;
    logic [XLEN-1:0]      mcand;
    logic [XLEN-1:0]      hi;
    logic [XLEN-1:0]      lo;
    logic                 valid_q;
    logic                 we_q;
    logic [REGADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]      rd_data_q;

    // Operand decode at accept
    logic            accept;
    logic            in_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_in;
    logic            div_zero;
    logic            div_ovf;
    logic            fast;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        accept   = (state == IDLE) && bus.i_valid && !bus.i_flush;
        in_div   = bus.i_op[2];
        a_signed = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
                   (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        b_signed = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) ||
                   (bus.i_op == 3'b110);
        a_neg    = a_signed && bus.i_rs1_data[XLEN-1];
        b_neg    = b_signed && bus.i_rs2_data[XLEN-1];
        a_mag    = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
        b_mag    = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_in   = (in_div && bus.i_op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = in_div && (bus.i_rs2_data == '0);
        div_ovf  = in_div && !bus.i_op[0] &&
                   (bus.i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (bus.i_rs2_data == '1);
        fast     = div_zero || div_ovf;
        if (div_zero)
            fast_result = bus.i_op[1] ? bus.i_rs1_data : '1;
        else
            fast_result = bus.i_op[1] ? '0 : bus.i_rs1_data;
    end

    // One iteration step and the sign-fixed result it would produce
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              take;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_result;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, mcand};
        take    = !diff[XLEN];
        if (op[2]) begin
            hi_n = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], take};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
        product  = {hi_n, lo_n};
        prod_fix = neg ? -product : product;
        quot_fix = neg ? -lo_n : lo_n;
        rem_fix  = neg ? -hi_n : hi_n;
        if (op[2])
            final_result = op[1] ? rem_fix : quot_fix;
        else if (op[1:0] == 2'b00)
            final_result = prod_fix[XLEN-1:0];
        else
            final_result = prod_fix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            count     <= '0;
            op        <= '0;
            neg       <= 1'b0;
            rd        <= '0;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            if (bus.i_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            op    <= bus.i_op;
                            neg   <= neg_in;
                            rd    <= bus.i_rd_addr;
                            mcand <= in_div ? b_mag : a_mag;
                            hi    <= '0;
                            lo    <= in_div ? a_mag : b_mag;
                            count <= '0;
                            if (fast) begin
                                state     <= DONE;
                                valid_q   <= 1'b1;
                                we_q      <= (bus.i_rd_addr != '0);
                                rd_addr_q <= bus.i_rd_addr;
                                rd_data_q <= fast_result;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        count <= count + 1'b1;
                        if (count == CW'(XLEN-1)) begin
                            state     <= DONE;
                            valid_q   <= 1'b1;
                            we_q      <= (rd != '0);
                            rd_addr_q <= rd;
                            rd_data_q <= final_result;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A flush landing on the DONE cycle must still cancel the write.
    assign bus.o_valid   = valid_q && !bus.i_flush;
    assign bus.o_rd_we   = we_q && !bus.i_flush;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd_data = rd_data_q;
    assign bus.o_ready   = (state == IDLE) && !i_reset;
    assign bus.o_hold    = ((state == IDLE) && bus.i_valid && !bus.i_flush) ||
                           (state == CALC);
endmodule
